// File: rtl/local_coincidence_gated_pkg.sv
// Shared mode constants and FSM state type for the local-coincidence former.
package lc_pkg;

   localparam logic LC_MODE_LEVEL = 1'b0;
   localparam logic LC_MODE_EVENT = 1'b1;

   typedef enum logic {
      ARMED   = 1'b0,
      HOLDOFF = 1'b1
   } lc_state_e;

endpackage

// File: rtl/local_coincidence_gated_if.sv
// Configuration, trigger and result bundle between the trigger path and the coincidence former.
interface lc_if #(
   parameter int N_CHANNELS  = 24,
   parameter int P_WIN_WIDTH = 16,
   parameter int P_CNT_WIDTH = 32
);
   logic [N_CHANNELS-1:0]  trig;
   logic [N_CHANNELS-1:0]  chan_mask;
   logic [P_WIN_WIDTH-1:0] lc_window_width;
   logic [7:0]             n_lc_thr;
   logic                   lc_mode;
   logic [P_WIN_WIDTH-1:0] lc_holdoff;
   logic                   lc_count_clr;
   logic [N_CHANNELS-1:0]  local_coinc;
   logic                   lc_fire;
   logic                   lc_busy;
   logic [P_CNT_WIDTH-1:0] lc_count;

   modport master (
      output trig, chan_mask, lc_window_width, n_lc_thr, lc_mode, lc_holdoff, lc_count_clr,
      input  local_coinc, lc_fire, lc_busy, lc_count
   );

   modport slave (
      input  trig, chan_mask, lc_window_width, n_lc_thr, lc_mode, lc_holdoff, lc_count_clr,
      output local_coinc, lc_fire, lc_busy, lc_count
   );
endinterface

// File: rtl/local_coincidence_gated_timer.sv
// Per-channel coincidence window: open while the down-counter is non-zero.
module lc_window_timer #(
   parameter int P_WIN_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_load,
   input  logic                   i_clear,
   input  logic                   i_en,
   input  logic [P_WIN_WIDTH-1:0] i_width,
   output logic                   o_open
);

   logic [P_WIN_WIDTH-1:0] r_timer;

   // NOTE: clocked state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer <= '0;
      end else if (i_load) begin
         r_timer <= i_width;
      end else if (i_clear) begin
         r_timer <= '0;
      end else if (i_en && (r_timer != '0)) begin
         r_timer <= r_timer - P_WIN_WIDTH'(1);
      end
   end

   assign o_open = (r_timer != '0);

endmodule

// File: rtl/local_coincidence_gated.sv
// Local-coincidence former: per-channel windows, popcount threshold, LEVEL/EVENT firing, fire counter.
module local_coincidence_gated
   import lc_pkg::*;
#(
   parameter int N_CHANNELS  = 24,
   parameter int P_WIN_WIDTH = 16,
   parameter int P_CNT_WIDTH = 32
) (
   input logic clk,
   input logic reset_n,
   lc_if.slave bus
);

   logic [N_CHANNELS-1:0]  r_trig_prev;
   logic [N_CHANNELS-1:0]  r_mask_prev;
   logic                   r_mode_prev;
   lc_state_e              r_state;
   logic [P_WIN_WIDTH-1:0] r_hold_cnt;
   logic                   r_fire;
   logic [N_CHANNELS-1:0]  r_coinc;
   logic [P_CNT_WIDTH-1:0] r_count;

   logic [N_CHANNELS-1:0]  w_pe;
   logic [N_CHANNELS-1:0]  w_cw;
   logic [N_CHANNELS-1:0]  w_load;
   logic [N_CHANNELS-1:0]  w_clear;
   logic [7:0]             w_level;
   logic                   w_hit;
   logic                   w_mode_chg;
   lc_state_e              w_state_nxt;
   logic [P_WIN_WIDTH-1:0] w_hold_nxt;
   logic                   w_fire_nxt;
   logic [N_CHANNELS-1:0]  w_coinc_nxt;
   logic                   w_clear_all;
   logic                   w_block_load;

   assign w_pe       = bus.trig & ~r_trig_prev & bus.chan_mask;
   assign w_mode_chg = (bus.lc_mode != r_mode_prev);

   // Load beats clear; a mask toggle clears only its own channel.
   assign w_load  = w_pe & {N_CHANNELS{(bus.lc_window_width != '0) && !w_block_load}};
   assign w_clear = {N_CHANNELS{w_clear_all}} | (bus.chan_mask ^ r_mask_prev);

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_win
      lc_window_timer #(.P_WIN_WIDTH(P_WIN_WIDTH)) u_timer (
         .clk     (clk),
         .reset_n (reset_n),
         .i_load  (w_load[g]),
         .i_clear (w_clear[g]),
         .i_en    (1'b1),
         .i_width (bus.lc_window_width),
         .o_open  (w_cw[g])
      );
   end

   always_comb begin
      w_level = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         w_level = w_level + 8'(w_cw[i]);
      end
   end

   assign w_hit = (bus.n_lc_thr != '0) && (w_level >= bus.n_lc_thr);

   // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold_cnt;
      w_fire_nxt   = 1'b0;
      w_coinc_nxt  = '0;
      w_clear_all  = 1'b0;
      w_block_load = 1'b0;
      case (bus.lc_mode)
         LC_MODE_LEVEL: begin
            w_fire_nxt  = w_hit;
            w_coinc_nxt = w_hit ? w_cw : '0;
            w_state_nxt = ARMED;
            w_hold_nxt  = '0;
         end
         LC_MODE_EVENT: begin
            case (r_state)
               ARMED: begin
                  if (w_hit) begin
                     w_fire_nxt   = 1'b1;
                     w_coinc_nxt  = w_cw;
                     w_clear_all  = 1'b1;
                     w_block_load = 1'b1;
                     if (bus.lc_holdoff != '0) begin
                        w_state_nxt = HOLDOFF;
                        w_hold_nxt  = bus.lc_holdoff;
                     end
                  end
               end
               HOLDOFF: begin
                  w_block_load = 1'b1;
                  if (r_hold_cnt <= P_WIN_WIDTH'(1)) begin
                     w_state_nxt = ARMED;
                     w_hold_nxt  = '0;
                  end else begin
                     w_hold_nxt = r_hold_cnt - P_WIN_WIDTH'(1);
                  end
               end
               default: w_state_nxt = ARMED;
            endcase
         end
         default: w_state_nxt = ARMED;
      endcase
      // A mode switch re-arms without touching the windows.
      if (w_mode_chg) begin
         w_state_nxt = ARMED;
         w_hold_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trig_prev <= '0;
         r_mask_prev <= '0;
         r_mode_prev <= LC_MODE_LEVEL;
         r_state     <= ARMED;
         r_hold_cnt  <= '0;
         r_fire      <= 1'b0;
         r_coinc     <= '0;
      end else begin
         r_trig_prev <= bus.trig;
         r_mask_prev <= bus.chan_mask;
         r_mode_prev <= bus.lc_mode;
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_fire      <= w_fire_nxt;
         r_coinc     <= w_coinc_nxt;
      end
   end

   // Counter advances on the same edge that raises lc_fire, so clear wins over that fire.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (bus.lc_count_clr) begin
         r_count <= '0;
      end else if (w_fire_nxt && (r_count != '1)) begin
         r_count <= r_count + P_CNT_WIDTH'(1);
      end
   end

   assign bus.local_coinc = r_coinc;
   assign bus.lc_fire     = r_fire;
   assign bus.lc_busy     = (r_state == HOLDOFF);
   assign bus.lc_count    = r_count;

endmodule

// File: tb/tb_local_coincidence_gated.sv
// Directed-vector bench for local_coincidence_gated; a 4-bit counter makes saturation reachable.
module tb_local_coincidence_gated;

   localparam int N_CH = 24;
   localparam int WW   = 16;
   localparam int CW   = 4;

   logic clk;
   logic reset_n;
   int   n_assert;
   int   n_fail;

   lc_if #(.N_CHANNELS(N_CH), .P_WIN_WIDTH(WW), .P_CNT_WIDTH(CW)) bus ();

   local_coincidence_gated #(.N_CHANNELS(N_CH), .P_WIN_WIDTH(WW), .P_CNT_WIDTH(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.trig         = '0;
      bus.lc_count_clr = 1'b0;
      reset_n          = 1'b0;
      #12;
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic config_lc(input logic mode, input logic [WW-1:0] w, input logic [7:0] thr,
                            input logic [WW-1:0] h, input logic [N_CH-1:0] mask);
      bus.lc_mode         = mode;
      bus.lc_window_width = w;
      bus.n_lc_thr        = thr;
      bus.lc_holdoff      = h;
      bus.chan_mask       = mask;
   endtask

   int   busy_n;
   logic any_fire;

   initial begin
      n_assert = 0;
      n_fail   = 0;

      // Reset state
      config_lc(1'b0, 16'd4, 8'd2, 16'd0, 24'hFFFFFF);
      do_reset();
      check("rst_fire", bus.lc_fire, 0);
      check("rst_coinc", bus.local_coinc, 0);
      check("rst_busy", bus.lc_busy, 0);
      check("rst_count", bus.lc_count, 0);

      // T1: LEVEL, W=4, thr=2; ch0 at k, ch5 at k+2 -> fire k+3..k+4
      bus.trig[0] = 1'b1; tick();          // k
      tick();                              // k+1
      bus.trig[5] = 1'b1; tick();          // k+2
      check("t1_fire_k2", bus.lc_fire, 0);
      tick();                              // k+3
      check("t1_fire_k3", bus.lc_fire, 1);
      check("t1_coinc_k3", bus.local_coinc, 24'h000021);
      tick();                              // k+4
      check("t1_fire_k4", bus.lc_fire, 1);
      check("t1_coinc_k4", bus.local_coinc, 24'h000021);
      tick();                              // k+5
      check("t1_fire_k5", bus.lc_fire, 0);
      check("t1_coinc_k5", bus.local_coinc, 0);
      check("t1_count", bus.lc_count, 2);

      // T2: EVENT, W=10, thr=3, H=5
      config_lc(1'b1, 16'd10, 8'd3, 16'd5, 24'hFFFFFF);
      do_reset();
      bus.trig[3:1] = 3'b111; tick();      // k
      check("t2_fire_k0", bus.lc_fire, 0);
      tick();                              // k+1
      check("t2_fire_k1", bus.lc_fire, 1);
      check("t2_coinc_k1", bus.local_coinc, 24'h00000E);
      busy_n   = int'(bus.lc_busy);
      any_fire = 1'b0;
      for (int i = 2; i <= 7; i++) begin
         tick();
         busy_n   += int'(bus.lc_busy);
         any_fire |= bus.lc_fire;
         if (i == 4) bus.trig[4] = 1'b1;   // edge at k+5, inside holdoff
      end
      check("t2_busy_cycles", busy_n, 5);
      check("t2_single_fire", any_fire, 0);
      check("t2_busy_end", bus.lc_busy, 0);
      bus.trig[6:5] = 2'b11; tick();       // k+8: only ch5/ch6 may open
      tick();                              // k+9
      check("t2_holdoff_edge_ignored", bus.lc_fire, 0);
      check("t2_count", bus.lc_count, 1);

      // T3: masked channel never fires; W=0 never opens
      config_lc(1'b0, 16'd8, 8'd1, 16'd0, 24'hFFFFFE);
      do_reset();
      any_fire = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.trig[0] = ~bus.trig[0];
         tick();
         any_fire |= bus.lc_fire;
      end
      check("t3_masked_no_fire", any_fire, 0);
      bus.trig = '0;
      bus.chan_mask = 24'hFFFFFF;
      bus.lc_window_width = 16'd0;
      tick(2);
      any_fire = 1'b0;
      bus.trig[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         any_fire |= bus.lc_fire;
      end
      check("t3_w0_no_fire", any_fire, 0);
      check("t3_count", bus.lc_count, 0);

      // T4: retrigger, W=3, thr=2; ch0 at k,k+2; ch1 at k+4
      config_lc(1'b0, 16'd3, 8'd2, 16'd0, 24'hFFFFFF);
      do_reset();
      bus.trig[0] = 1'b1; tick();          // k
      bus.trig[0] = 1'b0; tick();          // k+1
      bus.trig[0] = 1'b1; tick();          // k+2
      tick();                              // k+3
      bus.trig[1] = 1'b1; tick();          // k+4
      check("t4_fire_k4", bus.lc_fire, 0);
      tick();                              // k+5
      check("t4_fire_k5", bus.lc_fire, 1);
      check("t4_coinc_k5", bus.local_coinc, 24'h000003);
      tick();                              // k+6
      check("t4_fire_k6", bus.lc_fire, 0);

      // T5: counter saturation and clear priority
      config_lc(1'b0, 16'd14, 8'd1, 16'd0, 24'hFFFFFF);
      do_reset();
      bus.trig[0] = 1'b1; tick();          // k
      tick(14);                            // k+14
      check("t5_level_fire_k14", bus.lc_fire, 1);
      check("t5_count_max_m1", bus.lc_count, 14);
      tick();
      check("t5_level_fire_end", bus.lc_fire, 0);
      bus.trig = '0;
      bus.lc_mode = 1'b1;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         bus.trig[0] = 1'b1; tick();
         tick();
         check($sformatf("t5_event_fire%0d", i), bus.lc_fire, 1);
         check($sformatf("t5_count_sat%0d", i), bus.lc_count, 4'hF);
         bus.trig[0] = 1'b0; tick();
      end
      bus.trig[0] = 1'b1; tick();          // k
      bus.lc_count_clr = 1'b1; tick();     // k+1: fire with clear
      check("t5_clr_fire", bus.lc_fire, 1);
      check("t5_clr_count", bus.lc_count, 0);
      bus.lc_count_clr = 1'b0;
      bus.trig = '0;

      // T6: async reset during HOLDOFF
      config_lc(1'b1, 16'd10, 8'd2, 16'd20, 24'hFFFFFF);
      do_reset();
      bus.trig[1:0] = 2'b11; tick();       // k
      tick();                              // k+1
      check("t6_fire_pre", bus.lc_fire, 1);
      tick(3);
      check("t6_busy_pre", bus.lc_busy, 1);
      #2;
      reset_n  = 1'b0;
      bus.trig = '0;
      #1;
      check("t6_rst_fire", bus.lc_fire, 0);
      check("t6_rst_coinc", bus.local_coinc, 0);
      check("t6_rst_busy", bus.lc_busy, 0);
      check("t6_rst_count", bus.lc_count, 0);
      tick(2);
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);
      bus.trig[1:0] = 2'b11; tick();       // k
      tick();                              // k+1
      check("t6_fire_post", bus.lc_fire, 1);
      check("t6_coinc_post", bus.local_coinc, 24'h000003);
      check("t6_busy_post", bus.lc_busy, 1);
      check("t6_count_post", bus.lc_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
